// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus controller.
//   bus_state_t     : wait-state FSM encoding
//   IO_DEFAULT_BYTE : byte returned for unmapped IO and interrupt acknowledge
//   RST_CNT_W       : width of the power-on reset sequencer counter
package z80_bus_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    IO_WAIT = 1'b1
  } bus_state_t;

  localparam logic [7:0] IO_DEFAULT_BYTE = 8'hBF;
  localparam int         RST_CNT_W       = 32;

endpackage

// File: rtl/z80_clk_gen.sv
// CPU clock divider and power-on reset sequencer.
//   eclk   in  : system clock
//   _erst  in  : async active-low reset
//   clk    out : CPU clock, period 2*HALFCYCLE eclk cycles
//   _reset out : CPU reset, low while the sequencer count is in [RST_ASSERT, RST_RELEASE)
//   rise   out : high for the single eclk cycle in which clk has just gone high
module z80_clk_gen
  import z80_bus_pkg::*;
#(
  parameter int HALFCYCLE   = 100,
  parameter int RST_ASSERT  = 1000,
  parameter int RST_RELEASE = 2000
) (
  input  logic eclk,
  input  logic _erst,
  output logic clk,
  output logic _reset,
  output logic rise
);

  localparam int IW = $clog2(HALFCYCLE);

  logic [IW-1:0]        i;
  logic [RST_CNT_W-1:0] c;
  logic [RST_CNT_W-1:0] c_nxt;
  logic                 last_clk;

  // Saturating count; _reset is decoded from the next value so the
  // registered output lines up with the cycle in which c holds that value.
  always_comb begin
    c_nxt = c;
    if (c != '1) c_nxt = c + 1'b1;
  end

  always_ff @(posedge eclk or negedge _erst) begin
    if (!_erst) begin
      i        <= '0;
      clk      <= 1'b0;
      c        <= '0;
      _reset   <= 1'b1;
      last_clk <= 1'b0;
    end else begin
      last_clk <= clk;
      if (i == IW'(HALFCYCLE - 1)) begin
        i   <= '0;
        clk <= ~clk;
      end else begin
        i <= i + 1'b1;
      end
      c <= c_nxt;
      if (c_nxt == RST_CNT_W'(RST_ASSERT))  _reset <= 1'b0;
      if (c_nxt == RST_CNT_W'(RST_RELEASE)) _reset <= 1'b1;
    end
  end

  assign rise = clk & ~last_clk;

endmodule

// File: rtl/z80_bus_ctrl.sv
// Bus controller between the Z80 core and FPGA memory / IO channels.
//   eclk, _erst            : system clock, async active-low reset
//   clk, _reset            : generated CPU clock and CPU reset
//   ab, _iorq, _mreq, _wr, _m1, db_o : CPU bus
//   db_i, _wait            : CPU read data and wait request
//   mem_wr, mem_din, mem_dout : memory write strobe, write data, read data
//   io_cs, io_rnw, io_dout, io_ready : per-channel IO selects and handshake
// All bus decisions are taken only in the eclk cycle following a CPU rising
// edge, so strobes are one eclk wide and _wait is stable at CPU falling edges.
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int                  HALFCYCLE   = 100,
  parameter int                  RST_ASSERT  = 1000,
  parameter int                  RST_RELEASE = 2000,
  parameter int                  NUM_IO      = 2,
  parameter logic [NUM_IO*8-1:0] IO_BASE     = {8'h10, 8'hAA},
  parameter logic [NUM_IO*8-1:0] IO_MASK     = {8'hFF, 8'hFE},
  parameter logic [7:0]          IO_DEFAULT  = IO_DEFAULT_BYTE
) (
  input  logic                eclk,
  input  logic                _erst,
  output logic                clk,
  output logic                _reset,
  input  logic [15:0]         ab,
  input  logic                _iorq,
  input  logic                _mreq,
  input  logic                _wr,
  input  logic                _m1,
  input  logic [7:0]          db_o,
  output logic [7:0]          db_i,
  output logic                _wait,
  output logic                mem_wr,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout,
  output logic [NUM_IO-1:0]   io_cs,
  output logic                io_rnw,
  input  logic [NUM_IO*8-1:0] io_dout,
  input  logic [NUM_IO-1:0]   io_ready
);

  localparam int IDXW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

  logic                       rise;
  logic                       last_iorq;
  logic                       last_mw;
  logic                       mw_now;
  logic                       io_start;
  logic                       hit_any;
  logic [IDXW-1:0]            hit_idx;
  logic [NUM_IO-1:0]          hit_oh;
  logic [IDXW-1:0]            sel;
  bus_state_t                 state;
  logic [NUM_IO-1:0][7:0]     dout_a;
  logic                       unused_ab;

  z80_clk_gen #(
    .HALFCYCLE  (HALFCYCLE),
    .RST_ASSERT (RST_ASSERT),
    .RST_RELEASE(RST_RELEASE)
  ) u_clk_gen (
    .eclk   (eclk),
    ._erst  (_erst),
    .clk    (clk),
    ._reset (_reset),
    .rise   (rise)
  );

  // Only the low address byte is decoded for IO.
  assign unused_ab = &{1'b0, ab[15:8]};

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_IO - 1; k >= 0; k--) begin
      if ((ab[7:0] & IO_MASK[k*8 +: 8]) == IO_BASE[k*8 +: 8]) begin
        hit_any = 1'b1;
        hit_idx = IDXW'(k);
      end
    end
    hit_oh          = '0;
    hit_oh[hit_idx] = hit_any;
  end

  assign mw_now   = ~_mreq & ~_wr;
  // Interrupt acknowledge (_m1 low) never selects a channel.
  assign io_start = last_iorq & ~_iorq & _m1 & hit_any;

  always_ff @(posedge eclk or negedge _erst) begin
    if (!_erst) begin
      last_iorq <= 1'b0;
      last_mw   <= 1'b0;
      io_cs     <= '0;
      mem_wr    <= 1'b0;
      _wait     <= 1'b1;
      sel       <= '0;
      state     <= IDLE;
    end else begin
      io_cs  <= '0;
      mem_wr <= 1'b0;
      if (rise) begin
        last_iorq <= _iorq;
        last_mw   <= mw_now;
        if (io_start)          io_cs  <= hit_oh;
        if (!last_mw && mw_now) mem_wr <= 1'b1;
        case (state)
          IDLE: begin
            if (io_start && !io_ready[hit_idx]) begin
              state <= IO_WAIT;
              sel   <= hit_idx;
              _wait <= 1'b0;
            end
          end
          IO_WAIT: begin
            if (io_ready[sel]) begin
              state <= IDLE;
              _wait <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dout_a  = io_dout;
  assign io_rnw  = _wr;
  assign mem_din = db_o;

  always_comb begin
    db_i = IO_DEFAULT;
    if (_iorq)                db_i = mem_dout;
    else if (_m1 && hit_any)  db_i = dout_a[hit_idx];
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
module tb_z80_bus_ctrl;

  logic        eclk = 1'b0;
  logic        erst_n;
  logic        cpu_clk, cpu_rst_n;
  logic [15:0] ab;
  logic        iorq_n, mreq_n, wr_n, m1_n;
  logic [7:0]  db_o, db_i, mem_din, mem_dout;
  logic        wait_n, mem_wr, io_rnw;
  logic [1:0]  io_cs, io_ready;
  logic [15:0] io_dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] cs;
    logic       mw;
  } strobe_t;
  strobe_t sb_q[$];

  typedef struct {
    logic [15:0] ab;
    logic        wr;
    logic        m1;
    logic [1:0]  ready;
    logic [1:0]  cs;
    logic [7:0]  db;
  } vec_t;
  vec_t vecs[7];

  z80_bus_ctrl #(
    .HALFCYCLE  (4),
    .RST_ASSERT (40),
    .RST_RELEASE(80),
    .NUM_IO     (2),
    .IO_BASE    ({8'h10, 8'hAA}),
    .IO_MASK    ({8'hFF, 8'hFE}),
    .IO_DEFAULT (8'hBF)
  ) dut (
    .eclk     (eclk),
    ._erst    (erst_n),
    .clk      (cpu_clk),
    ._reset   (cpu_rst_n),
    .ab       (ab),
    ._iorq    (iorq_n),
    ._mreq    (mreq_n),
    ._wr      (wr_n),
    ._m1      (m1_n),
    .db_o     (db_o),
    .db_i     (db_i),
    ._wait    (wait_n),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .io_cs    (io_cs),
    .io_rnw   (io_rnw),
    .io_dout  (io_dout),
    .io_ready (io_ready)
  );

  always #5 eclk = ~eclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe cycle seen on the bus must match the next
  // expected entry; an extra cycle (e.g. a two-cycle pulse) is flagged.
  always @(negedge eclk) begin
    if (erst_n && (io_cs != 2'b00 || mem_wr)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got io_cs=%b mem_wr=%b expected none", io_cs, mem_wr);
      end else begin
        strobe_t e;
        e = sb_q.pop_front();
        chk("strobe", {29'd0, io_cs, mem_wr}, {29'd0, e.cs, e.mw});
      end
    end
  end

  // Advance on eclk falling edges until the CPU clock reaches lvl.
  task automatic wait_clk(input logic lvl);
    int t = 0;
    while (cpu_clk !== lvl && t < 100) begin
      @(negedge eclk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout_clk: got clk=%b expected %b", cpu_clk, lvl);
    end
  endtask

  task automatic cpu_fall();
    wait_clk(1'b1);
    wait_clk(1'b0);
  endtask

  // Sample n eclk cycles, counting deviations from the expected _wait and db_i.
  task automatic sample(input int n, input logic exp_wait, input logic [7:0] exp_db,
                        output int bad_w, output int bad_d);
    bad_w = 0;
    bad_d = 0;
    for (int s = 0; s < n; s++) begin
      @(negedge eclk);
      if (wait_n !== exp_wait) bad_w++;
      if (db_i !== exp_db) bad_d++;
    end
  endtask

  initial begin
    int bw, bd, bad_clk, bad_rst;

    vecs[0] = '{ab: 16'h00AB, wr: 1'b0, m1: 1'b1, ready: 2'b11, cs: 2'b01, db: 8'hC3};
    vecs[1] = '{ab: 16'h0010, wr: 1'b1, m1: 1'b1, ready: 2'b11, cs: 2'b10, db: 8'h5A};
    vecs[2] = '{ab: 16'h0055, wr: 1'b1, m1: 1'b1, ready: 2'b11, cs: 2'b00, db: 8'hBF};
    vecs[3] = '{ab: 16'h00AA, wr: 1'b1, m1: 1'b0, ready: 2'b11, cs: 2'b00, db: 8'hBF};
    vecs[4] = '{ab: 16'h12AA, wr: 1'b1, m1: 1'b1, ready: 2'b01, cs: 2'b01, db: 8'hC3};
    vecs[5] = '{ab: 16'h00AB, wr: 1'b0, m1: 1'b1, ready: 2'b11, cs: 2'b01, db: 8'hC3};
    vecs[6] = '{ab: 16'h0011, wr: 1'b1, m1: 1'b1, ready: 2'b11, cs: 2'b00, db: 8'hBF};

    erst_n   = 1'b0;
    ab       = 16'h0000;
    iorq_n   = 1'b1;
    mreq_n   = 1'b1;
    wr_n     = 1'b1;
    m1_n     = 1'b1;
    db_o     = 8'h3C;
    mem_dout = 8'h77;
    io_dout  = 16'h5AC3;
    io_ready = 2'b11;

    // Reset state
    repeat (3) @(negedge eclk);
    chk("rst_clk",    {31'd0, cpu_clk},   32'd0);
    chk("rst_reset",  {31'd0, cpu_rst_n}, 32'd1);
    chk("rst_wait",   {31'd0, wait_n},    32'd1);
    chk("rst_mem_wr", {31'd0, mem_wr},    32'd0);
    chk("rst_io_cs",  {30'd0, io_cs},     32'd0);

    // Clock divider and reset sequencer: after eclk edge n the count is n.
    erst_n  = 1'b1;
    bad_clk = 0;
    bad_rst = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge eclk);
      if (cpu_clk !== 1'(((n / 4) % 2))) bad_clk++;
      if (cpu_rst_n !== ((n >= 40 && n < 80) ? 1'b0 : 1'b1)) bad_rst++;
    end
    chk("clk_divider", bad_clk, 0);
    chk("reset_seq",   bad_rst, 0);
    chk("mem_passthru", {24'd0, db_i}, {24'd0, 8'h77});
    chk("mem_din",      {24'd0, mem_din}, {24'd0, 8'h3C});

    // Table of single IO cycles on ready or unmapped channels.
    for (int v = 0; v < 7; v++) begin
      cpu_fall();
      ab       = vecs[v].ab;
      wr_n     = vecs[v].wr;
      m1_n     = vecs[v].m1;
      io_ready = vecs[v].ready;
      iorq_n   = 1'b0;
      if (vecs[v].cs != 2'b00) sb_q.push_back('{cs: vecs[v].cs, mw: 1'b0});
      sample(24, 1'b1, vecs[v].db, bw, bd);
      chk($sformatf("vec%0d_wait", v), bw, 0);
      chk($sformatf("vec%0d_db", v), bd, 0);
      chk($sformatf("vec%0d_rnw", v), {31'd0, io_rnw}, {31'd0, vecs[v].wr});
      iorq_n = 1'b1;
      wr_n   = 1'b1;
      m1_n   = 1'b1;
      cpu_fall();
      chk($sformatf("vec%0d_sb", v), sb_q.size(), 0);
    end

    // Slow channel 1 read: wait state until ready is seen at a rise.
    cpu_fall();
    ab       = 16'h0010;
    io_ready = 2'b01;
    iorq_n   = 1'b0;
    sb_q.push_back('{cs: 2'b10, mw: 1'b0});
    wait_clk(1'b1);
    chk("slow_wait_at_rise", {31'd0, wait_n}, 32'd1);
    @(negedge eclk);
    chk("slow_wait_low", {31'd0, wait_n}, 32'd0);
    sample(24, 1'b0, 8'h5A, bw, bd);
    chk("slow_wait_held", bw, 0);
    chk("slow_db", bd, 0);
    wait_clk(1'b0);
    io_ready = 2'b11;
    wait_clk(1'b1);
    chk("slow_wait_rise_cyc", {31'd0, wait_n}, 32'd0);
    @(negedge eclk);
    chk("slow_wait_release", {31'd0, wait_n}, 32'd1);
    iorq_n = 1'b1;
    cpu_fall();
    chk("slow_sb", sb_q.size(), 0);

    // Memory writes held for several CPU clocks give one pulse each.
    for (int w = 0; w < 2; w++) begin
      cpu_fall();
      mreq_n = 1'b0;
      wr_n   = 1'b0;
      db_o   = 8'(8'hE0 + w);
      sb_q.push_back('{cs: 2'b00, mw: 1'b1});
      sample(24, 1'b1, 8'h77, bw, bd);
      chk($sformatf("memwr%0d_wait", w), bw, 0);
      chk($sformatf("memwr%0d_din", w), {24'd0, mem_din}, {24'd0, 8'(8'hE0 + w)});
      mreq_n = 1'b1;
      wr_n   = 1'b1;
      cpu_fall();
      chk($sformatf("memwr%0d_sb", w), sb_q.size(), 0);
    end

    // Simultaneous IO and memory write: both strobes in the same cycle.
    cpu_fall();
    ab     = 16'h00AB;
    iorq_n = 1'b0;
    mreq_n = 1'b0;
    wr_n   = 1'b0;
    sb_q.push_back('{cs: 2'b01, mw: 1'b1});
    sample(16, 1'b1, 8'hC3, bw, bd);
    iorq_n = 1'b1;
    mreq_n = 1'b1;
    wr_n   = 1'b1;
    cpu_fall();
    chk("both_sb", sb_q.size(), 0);

    // Reset while in a wait state.
    cpu_fall();
    ab       = 16'h0010;
    io_ready = 2'b01;
    iorq_n   = 1'b0;
    sb_q.push_back('{cs: 2'b10, mw: 1'b0});
    wait_clk(1'b1);
    repeat (3) @(negedge eclk);
    chk("midwait_low", {31'd0, wait_n}, 32'd0);
    chk("midwait_sb", sb_q.size(), 0);
    erst_n = 1'b0;
    #1;
    chk("midrst_wait",  {31'd0, wait_n},    32'd1);
    chk("midrst_clk",   {31'd0, cpu_clk},   32'd0);
    chk("midrst_reset", {31'd0, cpu_rst_n}, 32'd1);
    iorq_n = 1'b1;
    repeat (2) @(negedge eclk);
    erst_n = 1'b1;
    sample(40, 1'b1, 8'h77, bw, bd);
    chk("post_rst_idle", bw, 0);

    // Controller still serves IO after the mid-wait reset.
    cpu_fall();
    ab       = 16'h00AB;
    io_ready = 2'b11;
    iorq_n   = 1'b0;
    sb_q.push_back('{cs: 2'b01, mw: 1'b0});
    sample(16, 1'b1, 8'hC3, bw, bd);
    chk("post_rst_io_db", bd, 0);
    iorq_n = 1'b1;
    cpu_fall();
    chk("post_rst_sb", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_bus_ctrl.md
# z80_bus_ctrl

Parametrised bus controller between the gate-level Z80 core and FPGA-side memory and peripherals. It generates the CPU clock and power-on reset from `eclk`, and decodes CPU bus cycles into one-`eclk` memory-write and per-channel IO chip-select strobes. It also inserts Z80 wait states for slow IO channels and muxes read data back onto `db_i`. It replaces hard-wired single-UART glue with `NUM_IO` decoded channels.

## Interface
Reset is asynchronous and active-low.

Parameters:
- `HALFCYCLE`, 100: `eclk` cycles per CPU clock half-period; must be ≥ 2.
- `RST_ASSERT`, 1000: `eclk` count at which `_reset` falls.
- `RST_RELEASE`, 2000: `eclk` count at which `_reset` rises; must be greater than `RST_ASSERT`.
- `NUM_IO`, 2: number of IO channels, from 1 to 8.
- `IO_BASE`, {8'h10, 8'hAA}: packed `NUM_IO*8`; byte k is the base address of channel k.
- `IO_MASK`, {8'hFF, 8'hFE}: packed `NUM_IO*8`; byte k is the compare mask for channel k.
- `IO_DEFAULT`, 8'hBF: read value for unmapped IO and for interrupt acknowledge.

Ports:
- `eclk`  in  1  system clock.
- `_erst`  in  1  asynchronous active-low reset.
- `clk`  out  1  CPU clock.
- `_reset`  out  1  CPU reset, active-low.
- `ab`  in  16  CPU address.
- `_iorq`, `_mreq`, `_wr`, `_m1`  in  1 each  CPU strobes.
- `db_o`  in  8  CPU write data; passed through to `mem_din`.
- `db_i`  out  8  CPU read data.
- `_wait`  out  1  CPU wait request, active-low.
- `mem_wr`  out  1  memory write strobe, one `eclk` wide.
- `mem_dout`  in  8  memory read data.
- `io_cs`  out  `NUM_IO`  per-channel select, one `eclk` wide.
- `io_rnw`  out  1  equals `_wr`.
- `io_dout`  in  `NUM_IO*8`  per-channel read data.
- `io_ready`  in  `NUM_IO`  per-channel ready.

## Operation
- **Reset values:** `clk` = 0, `_reset` = 1, `_wait` = 1, `mem_wr` = 0, `io_cs` = 0. All counters and edge registers are cleared and the FSM is in IDLE. Reset asserted mid-cycle aborts any wait state immediately.
- **Clock divider:** counter `i` runs 0..`HALFCYCLE`-1. When `i` = `HALFCYCLE`-1, `i` wraps to 0 and `clk` toggles.
- **Reset sequencer:** counter `c` increments once per `eclk` and saturates at all-ones, with no wrap.
  - `_reset` falls on the cycle `c` = `RST_ASSERT`.
  - `_reset` rises on the cycle `c` = `RST_RELEASE`.
  - `_reset` does not reassert until `_erst` is asserted again.
- **Edge detect:** `rise` is true in the `eclk` cycle where `clk` = 1 and `last_clk` = 0. Every bus decision below is evaluated only in `rise` cycles.
- **Channel decode:**
  - Channel k matches when `(ab[7:0] & IO_MASK[k]) == IO_BASE[k]`.
  - If several channels match, the lowest index wins.
  - An IO cycle with `_m1` = 0 is interrupt acknowledge; it never selects a channel.
- **IO strobe:** `last_iorq` samples `_iorq` at each `rise`. When `last_iorq` = 1, `_iorq` = 0, `_m1` = 1 and channel k matches, `io_cs[k]` is 1 for exactly the next `eclk` cycle.
- **Memory write strobe:** `last_mw` samples `(!_mreq & !_wr)` at each `rise`. When `last_mw` = 0 and `(!_mreq & !_wr)` = 1, `mem_wr` is 1 for exactly the next `eclk` cycle.
- **Wait FSM:** states IDLE and IO_WAIT; the selected channel index is latched on entry to IO_WAIT.
  - IDLE → IO_WAIT when an `io_cs[k]` is issued and `io_ready[k]` = 0 in that same `rise` cycle; `_wait` is registered to 0.
  - IO_WAIT → IDLE at the first `rise` with `io_ready[k]` = 1; `_wait` is registered to 1.
  - `_wait` changes only one `eclk` after a `rise`, so it is stable at every CPU falling edge.
- **Read mux (combinational):**
  - `_iorq` = 1 → `db_i` = `mem_dout`.
  - `_iorq` = 0 and a channel is selected → `db_i` = `io_dout[k]`.
  - Otherwise → `db_i` = `IO_DEFAULT`.

## Timing
- `clk` period is 2·`HALFCYCLE` `eclk` cycles. The first `clk` rise occurs `HALFCYCLE` cycles after `_erst` deasserts.
- `io_cs` and `mem_wr` appear one `eclk` after the detecting `rise`, which is the first CPU rising edge after the strobe falls.
- `io_ready` sampled high at `rise` n releases `_wait` one `eclk` after `rise` n. Added latency is a whole number of CPU clocks.
- A back-to-back IO cycle to the same channel produces a fresh `io_cs`, because `last_iorq` sees `_iorq` high between cycles.
- A simultaneous `_iorq` and `_mreq` fall (not legal on a Z80) must produce both strobes independently.
- `io_ready` is ignored in IDLE unless an `io_cs` is being issued in that `rise` cycle.

## Structure
- Package `z80_bus_pkg`:
  - FSM state enum (IDLE, IO_WAIT).
  - `IO_DEFAULT_BYTE` = 8'hBF.
  - Width constant for the reset counter (32).
- Sub-module `z80_clk_gen` holds the clock divider and reset sequencer. Outputs: `clk`, `_reset`, `rise`.
- Decode, strobes, wait FSM and read mux stay in `z80_bus_ctrl`.

## Test plan
Bench parameters for all scenarios: `HALFCYCLE` = 4, `RST_ASSERT` = 40, `RST_RELEASE` = 80, channel 0 at 8'hAA with mask 8'hFE, channel 1 at 8'h10 with mask 8'hFF.
- **Reset and clock:** release `_erst`. Require `clk` toggles every 4 `eclk`, `_reset` = 0 for `c` in 40..79, and `_reset` returns to 1 at 80 and stays there.
- **IO write, ready channel:** `_iorq` falls with `ab` = 16'h00AB, `_wr` = 0 and `io_ready` = 2'b11. Require exactly one `io_cs` = 2'b01 pulse and `_wait` held at 1.
- **IO read, slow channel:** IO read of 8'h10 with `io_ready[1]` = 0; raise it 3 CPU clocks later. Require `io_cs` = 2'b10 once, `_wait` = 0 until one `eclk` after the next `rise`, and `db_i` = `io_dout[15:8]`.
- **Unmapped IO and interrupt acknowledge:** IO read of 8'h55, then a cycle with `_iorq` = 0 and `_m1` = 0 at 8'hAA. Require `db_i` = 8'hBF in both and `io_cs` = 0 in both.
- **Memory write:** `_mreq` = 0, `_wr` = 0 held for 3 CPU clocks. Require one `mem_wr` pulse; a second write cycle produces a second pulse.
- **Reset mid-wait:** pull `_erst` low while in IO_WAIT. Require `_wait` = 1, `clk` = 0 and `_reset` = 1 immediately, and the FSM in IDLE after release.
